// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera configuration sequencer.
package cam_cfg_pkg;

  localparam int unsigned ENTRY_W  = 24;
  localparam logic [15:0] ADDR_END = 16'hFFFF;
  localparam logic [15:0] ADDR_DLY = 16'hFFFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWR_WAIT,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_DELAY,
    ST_FINISH,
    ST_FAIL
  } cam_state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } cam_entry_t;

endpackage

// File: rtl/cam_cfg_rom.sv
// Synchronous configuration table, one-cycle read latency.
// Contents come from a packed init vector, entry 0 in the least significant bits.
module cam_cfg_rom
  import cam_cfg_pkg::*;
#(
  parameter int unsigned                       TBL_DEPTH = 64,
  parameter logic [ENTRY_W*TBL_DEPTH-1:0]      ROM_INIT  = '1
) (
  input  logic                         ILA_clk,
  input  logic                         rstn,
  input  logic [$clog2(TBL_DEPTH)-1:0] i_addr,
  output cam_entry_t                   o_q
);

  cam_entry_t w_tbl [TBL_DEPTH];
  cam_entry_t r_q;

  for (genvar g = 0; g < TBL_DEPTH; g++) begin : g_tbl
    assign w_tbl[g] = ROM_INIT[g*ENTRY_W +: ENTRY_W];
  end

  always_ff @(posedge ILA_clk or negedge rstn) begin
    if (!rstn) r_q <= '0;
    else       r_q <= w_tbl[i_addr];
  end

  assign o_q = r_q;

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Camera power-up and SCCB register-table sequencer with per-entry retry
// and table-driven delays.
module cam_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter logic [31:0]                  PWR_DLY_CYC  = 32'd5_000_000,
  parameter logic [31:0]                  DLY_UNIT_CYC = 32'd50_000,
  parameter int unsigned                  TBL_DEPTH    = 64,
  parameter int unsigned                  RETRY_MAX    = 3,
  parameter logic [ENTRY_W*TBL_DEPTH-1:0] ROM_INIT     = '1
) (
  input  logic                         ILA_clk,
  input  logic                         rstn,
  input  logic                         start,
  output logic                         cam_en,
  output logic                         sccb_req,
  output logic [15:0]                  sccb_addr,
  output logic [7:0]                   sccb_data,
  input  logic                         sccb_ack,
  input  logic                         sccb_nack,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [$clog2(TBL_DEPTH)-1:0] err_idx
);

  localparam int unsigned IDX_W = $clog2(TBL_DEPTH);
  localparam int unsigned RTY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  cam_state_e       r_state;
  logic [31:0]      r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [RTY_W-1:0] r_rty;
  logic             r_rom_vld;
  logic             r_cam_en;
  logic             r_req;
  logic [15:0]      r_addr;
  logic [7:0]       r_data;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [IDX_W-1:0] r_err_idx;
  cam_entry_t       w_ent;
  logic             w_last;

  cam_cfg_rom #(
    .TBL_DEPTH (TBL_DEPTH),
    .ROM_INIT  (ROM_INIT)
  ) u_rom (
    .ILA_clk (ILA_clk),
    .rstn    (rstn),
    .i_addr  (r_idx),
    .o_q     (w_ent)
  );

  // Running past the last slot ends the sequence like an end marker.
  assign w_last = (r_idx == IDX_W'(TBL_DEPTH - 1));

  always_ff @(posedge ILA_clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rty     <= '0;
      r_rom_vld <= 1'b0;
      r_cam_en  <= 1'b0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_err_idx <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_busy   <= 1'b1;
            r_cam_en <= 1'b1;
            r_cnt    <= PWR_DLY_CYC;
            r_state  <= ST_PWR_WAIT;
          end
        end
        ST_PWR_WAIT: begin
          if (r_cnt <= 32'd1) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_rty     <= '0;
            r_rom_vld <= 1'b0;
            r_state   <= ST_FETCH;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        // First cycle waits for the ROM, second cycle decodes the entry.
        ST_FETCH: begin
          if (!r_rom_vld) begin
            r_rom_vld <= 1'b1;
          end else begin
            r_rom_vld <= 1'b0;
            if (w_ent.addr == ADDR_END) begin
              r_state <= ST_FINISH;
            end else if (w_ent.addr == ADDR_DLY) begin
              r_cnt   <= 32'(w_ent.data) * DLY_UNIT_CYC;
              r_state <= ST_DELAY;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_req   <= 1'b1;
          r_addr  <= w_ent.addr;
          r_data  <= w_ent.data;
          r_state <= ST_WAIT_RSP;
        end
        // nack wins over a coincident ack.
        ST_WAIT_RSP: begin
          if (sccb_nack) begin
            r_req <= 1'b0;
            if (32'(r_rty) < RETRY_MAX) begin
              r_rty   <= r_rty + RTY_W'(1);
              r_state <= ST_ISSUE;
            end else begin
              r_err_idx <= r_idx;
              r_state   <= ST_FAIL;
            end
          end else if (sccb_ack) begin
            r_req <= 1'b0;
            r_rty <= '0;
            if (w_last) begin
              r_state <= ST_FINISH;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_FETCH;
            end
          end
        end
        ST_DELAY: begin
          if (r_cnt <= 32'd1) begin
            r_cnt <= '0;
            if (w_last) begin
              r_state <= ST_FINISH;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_FETCH;
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_FAIL: begin
          r_error  <= 1'b1;
          r_busy   <= 1'b0;
          r_cam_en <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cam_en    = r_cam_en;
  assign sccb_req  = r_req;
  assign sccb_addr = r_addr;
  assign sccb_data = r_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign err_idx   = r_err_idx;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Bench for cam_cfg_sequencer: two instances with different tables, driven
// through a shared responder and checked against a table-walking model.
module tb_cam_cfg_sequencer;
  import cam_cfg_pkg::*;

  localparam int PWR_A  = 10;
  localparam int UNIT_A = 4;
  localparam int PWR_B  = 7;
  localparam int UNIT_B = 3;
  localparam int DEPTH  = 4;
  localparam int RMAX   = 3;

  localparam logic [95:0] ROM_A = {24'hFFFF00, 24'h010001, 24'hFFFE02, 24'h300882};
  localparam logic [95:0] ROM_B = {24'h010001, 24'hFFFE00, 24'h123456, 24'h300882};

  cam_entry_t tbl_a [DEPTH];
  cam_entry_t tbl_b [DEPTH];

  logic ILA_clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic sccb_ack = 1'b0;
  logic sccb_nack = 1'b0;
  logic sel = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   resp_q [$];

  logic        a_cam_en, a_req, a_busy, a_done, a_error;
  logic [15:0] a_addr;
  logic [7:0]  a_data;
  logic [1:0]  a_eidx;
  logic        b_cam_en, b_req, b_busy, b_done, b_error;
  logic [15:0] b_addr;
  logic [7:0]  b_data;
  logic [1:0]  b_eidx;

  logic        m_cam_en, m_req, m_busy, m_done, m_error;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  logic [1:0]  m_eidx;

  always #5 ILA_clk = ~ILA_clk;
  always @(posedge ILA_clk) cyc <= cyc + 1;

  cam_cfg_sequencer #(
    .PWR_DLY_CYC(32'(PWR_A)), .DLY_UNIT_CYC(32'(UNIT_A)),
    .TBL_DEPTH(DEPTH), .RETRY_MAX(RMAX), .ROM_INIT(ROM_A)
  ) dut_a (
    .ILA_clk(ILA_clk), .rstn(rstn), .start(start & ~sel),
    .cam_en(a_cam_en), .sccb_req(a_req), .sccb_addr(a_addr), .sccb_data(a_data),
    .sccb_ack(sccb_ack), .sccb_nack(sccb_nack),
    .busy(a_busy), .done(a_done), .error(a_error), .err_idx(a_eidx)
  );

  cam_cfg_sequencer #(
    .PWR_DLY_CYC(32'(PWR_B)), .DLY_UNIT_CYC(32'(UNIT_B)),
    .TBL_DEPTH(DEPTH), .RETRY_MAX(RMAX), .ROM_INIT(ROM_B)
  ) dut_b (
    .ILA_clk(ILA_clk), .rstn(rstn), .start(start & sel),
    .cam_en(b_cam_en), .sccb_req(b_req), .sccb_addr(b_addr), .sccb_data(b_data),
    .sccb_ack(sccb_ack), .sccb_nack(sccb_nack),
    .busy(b_busy), .done(b_done), .error(b_error), .err_idx(b_eidx)
  );

  assign m_cam_en = sel ? b_cam_en : a_cam_en;
  assign m_req    = sel ? b_req    : a_req;
  assign m_busy   = sel ? b_busy   : a_busy;
  assign m_done   = sel ? b_done   : a_done;
  assign m_error  = sel ? b_error  : a_error;
  assign m_addr   = sel ? b_addr   : a_addr;
  assign m_data   = sel ? b_data   : a_data;
  assign m_eidx   = sel ? b_eidx   : a_eidx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cam_en"}, 32'(m_cam_en), 32'd0);
    chk({tag, "_req"},    32'(m_req),    32'd0);
    chk({tag, "_busy"},   32'(m_busy),   32'd0);
    chk({tag, "_done"},   32'(m_done),   32'd0);
    chk({tag, "_error"},  32'(m_error),  32'd0);
    chk({tag, "_addr"},   32'(m_addr),   32'd0);
    chk({tag, "_data"},   32'(m_data),   32'd0);
    chk({tag, "_eidx"},   32'(m_eidx),   32'd0);
  endtask

  // mode 0: ack, random latency; 1: nack always; 2: random responses and
  // stray acks; 3: ack exactly 3 cycles after req. resp_q entries override.
  task automatic run_seq(input bit s, input int mode, input bit poke, output int n_req);
    cam_entry_t tbl [DEPTH];
    int pwr, unit, idx, rty, need, gap, t0, t_fall, d, resp, budget;
    bit exp_fail, first;
    logic [1:0] exp_eidx;
    if (s) begin tbl = tbl_b; pwr = PWR_B; unit = UNIT_B; end
    else   begin tbl = tbl_a; pwr = PWR_A; unit = UNIT_A; end
    sel = s;
    @(negedge ILA_clk);
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge ILA_clk);
    start = 1'b0;
    chk("start_busy",   32'(m_busy),   32'd1);
    chk("start_cam_en", 32'(m_cam_en), 32'd1);
    chk("start_done",   32'(m_done),   32'd0);
    chk("start_error",  32'(m_error),  32'd0);
    if (poke) begin
      repeat (2) @(negedge ILA_clk);
      start = 1'b1;
      @(negedge ILA_clk);
      start = 1'b0;
    end
    idx = 0; rty = 0; exp_fail = 1'b0; exp_eidx = '0; first = 1'b1; n_req = 0; t_fall = 0;
    forever begin
      need = 1;
      while (idx < DEPTH && tbl[idx].addr == 16'hFFFE) begin
        need += (tbl[idx].data == 8'd0) ? 1 : int'(tbl[idx].data) * unit;
        idx++;
      end
      if (idx >= DEPTH || tbl[idx].addr == 16'hFFFF) break;
      budget = 0;
      while (!m_req && budget < 500) begin
        sccb_ack = (mode == 2) && ($urandom_range(0, 5) == 0);
        @(negedge ILA_clk);
        sccb_ack = 1'b0;
        budget++;
      end
      chk("req_seen", 32'(m_req), 32'd1);
      if (!m_req) break;
      n_req++;
      chk("req_addr", 32'(m_addr), 32'(tbl[idx].addr));
      chk("req_data", 32'(m_data), 32'(tbl[idx].data));
      if (first) begin
        chk("first_req_lat", 32'(cyc - t0), 32'(pwr + 3));
      end else begin
        gap = cyc - t_fall;
        chk("req_gap", 32'((gap >= need) ? need : gap), 32'(need));
      end
      first = 1'b0;
      d = (mode == 3) ? 2 : int'($urandom_range(0, 4));
      repeat (d) begin
        @(negedge ILA_clk);
        chk("req_hold", {7'd0, m_req, m_addr, m_data}, {7'd0, 1'b1, tbl[idx].addr, tbl[idx].data});
      end
      if (resp_q.size() > 0) resp = resp_q.pop_front();
      else if (mode == 1)    resp = 1;
      else if (mode == 2) begin
        resp = int'($urandom_range(0, 5));
        resp = (resp <= 3) ? 0 : resp - 3;
      end else resp = 0;
      sccb_ack  = (resp != 1);
      sccb_nack = (resp != 0);
      @(negedge ILA_clk);
      sccb_ack  = 1'b0;
      sccb_nack = 1'b0;
      chk("req_drop", 32'(m_req), 32'd0);
      t_fall = cyc;
      if (resp != 0) begin
        if (rty < RMAX) rty++;
        else begin exp_fail = 1'b1; exp_eidx = 2'(idx); break; end
      end else begin
        rty = 0;
        idx++;
      end
    end
    budget = 0;
    while (m_busy && budget < 500) begin @(negedge ILA_clk); budget++; end
    chk("end_busy",   32'(m_busy),   32'd0);
    chk("end_req",    32'(m_req),    32'd0);
    chk("end_done",   32'(m_done),   32'(!exp_fail));
    chk("end_error",  32'(m_error),  32'(exp_fail));
    chk("end_cam_en", 32'(m_cam_en), 32'(!exp_fail));
    if (exp_fail) chk("end_err_idx", 32'(m_eidx), 32'(exp_eidx));
  endtask

  initial begin
    int n, budget;
    tbl_a = '{'{16'h3008, 8'h82}, '{16'hFFFE, 8'h02}, '{16'h0100, 8'h01}, '{16'hFFFF, 8'h00}};
    tbl_b = '{'{16'h3008, 8'h82}, '{16'h1234, 8'h56}, '{16'hFFFE, 8'h00}, '{16'h0100, 8'h01}};

    // Reset values on both instances.
    repeat (3) @(negedge ILA_clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk_reset_vals("reset");
    end
    @(negedge ILA_clk);
    rstn = 1'b1;

    // Nominal run with fixed 3-cycle ack latency.
    run_seq(1'b0, 3, 1'b0, n);
    chk("nominal_nreq", 32'(n), 32'd2);

    // Restart after finish: two nacks on entry 0, then ack.
    resp_q = '{1, 1, 0};
    run_seq(1'b0, 3, 1'b0, n);
    chk("retry_nreq", 32'(n), 32'd4);

    // Retry exhaustion on entry 0.
    run_seq(1'b0, 1, 1'b0, n);
    chk("exhaust_nreq", 32'(n), 32'(RMAX + 1));

    // Restart after failure, with a start pulse during the power delay.
    run_seq(1'b0, 0, 1'b1, n);
    chk("restart_nreq", 32'(n), 32'd2);

    // Simultaneous ack+nack on entry 1; table without end marker.
    resp_q = '{0, 2};
    run_seq(1'b1, 0, 1'b0, n);
    chk("both_nreq", 32'(n), 32'd4);

    // Asynchronous reset while a write is outstanding.
    sel = 1'b0;
    @(negedge ILA_clk);
    start = 1'b1;
    @(negedge ILA_clk);
    start = 1'b0;
    budget = 0;
    while (!m_req && budget < 500) begin @(negedge ILA_clk); budget++; end
    chk("rst_pre_req", 32'(m_req), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge ILA_clk);
    rstn = 1'b1;
    run_seq(1'b0, 0, 1'b0, n);
    chk("post_rst_nreq", 32'(n), 32'd2);

    // Randomised responses on either instance.
    for (int i = 0; i < 10; i++) begin
      run_seq(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
